// File: rtl/claim_scan_pkg.sv
// Shared types for the claim overlap scanner: FSM state encoding and scan mode values.
package claim_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_FIND  = 1'b0;
  localparam logic MODE_COUNT = 1'b1;

endpackage

// File: rtl/rect_overlap_cmp.sv
// Strict area-overlap test of two claims; edges are widened by one bit so right/bottom never wrap.
module rect_overlap_cmp #(
  parameter int COORD_W = 10,
  parameter int SIZE_W  = 5
) (
  input  logic [COORD_W-1:0] left_a,
  input  logic [COORD_W-1:0] top_a,
  input  logic [SIZE_W-1:0]  w_a,
  input  logic [SIZE_W-1:0]  h_a,
  input  logic [COORD_W-1:0] left_b,
  input  logic [COORD_W-1:0] top_b,
  input  logic [SIZE_W-1:0]  w_b,
  input  logic [SIZE_W-1:0]  h_b,
  output logic               overlap
);

  logic [COORD_W:0] l_a_s, r_a_s, t_a_s, b_a_s;
  logic [COORD_W:0] l_b_s, r_b_s, t_b_s, b_b_s;

  // Touching edges and zero-area claims fall out of the strict compares.
  always_comb begin
    l_a_s = {1'b0, left_a};
    t_a_s = {1'b0, top_a};
    l_b_s = {1'b0, left_b};
    t_b_s = {1'b0, top_b};
    r_a_s = l_a_s + (COORD_W+1)'(w_a);
    b_a_s = t_a_s + (COORD_W+1)'(h_a);
    r_b_s = l_b_s + (COORD_W+1)'(w_b);
    b_b_s = t_b_s + (COORD_W+1)'(h_b);
    overlap = !((l_a_s >= r_b_s) || (r_a_s <= l_b_s) ||
                (t_a_s >= b_b_s) || (b_a_s <= t_b_s));
  end

endmodule

// File: rtl/claim_overlap_scanner.sv
// All-pairs claim overlap scanner: issues (i,j) reads one pair per cycle, compares one cycle later,
// and either reports the first isolated claim (mode 0) or counts overlapping claims (mode 1).
module claim_overlap_scanner
  import claim_scan_pkg::*;
#(
  parameter int N_CLAIMS = 1237,
  parameter int IDX_W    = 11,
  parameter int COORD_W  = 10,
  parameter int SIZE_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   rd_addr_a,
  output logic [IDX_W-1:0]   rd_addr_b,
  input  logic [COORD_W-1:0] rd_left_a,
  input  logic [COORD_W-1:0] rd_top_a,
  input  logic [SIZE_W-1:0]  rd_w_a,
  input  logic [SIZE_W-1:0]  rd_h_a,
  input  logic [COORD_W-1:0] rd_left_b,
  input  logic [COORD_W-1:0] rd_top_b,
  input  logic [SIZE_W-1:0]  rd_w_b,
  input  logic [SIZE_W-1:0]  rd_h_b,
  output logic               found,
  output logic [IDX_W-1:0]   result_idx,
  output logic [IDX_W:0]     result_cnt
);

  localparam logic [IDX_W-1:0] LAST     = IDX_W'(N_CLAIMS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1'b1);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [IDX_W-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic               iss_v_q, iss_v_d;
  logic [IDX_W-1:0]   cmp_i_q, cmp_i_d, cmp_j_q, cmp_j_d;
  logic               cmp_v_q, cmp_v_d;
  logic               row_hit_q, row_hit_d;
  logic               busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W:0]     cnt_q, cnt_d;
  logic               pair_ovl_s, hit_s, row_end_s;

  rect_overlap_cmp #(.COORD_W(COORD_W), .SIZE_W(SIZE_W)) u_cmp (
    .left_a (rd_left_a), .top_a (rd_top_a), .w_a (rd_w_a), .h_a (rd_h_a),
    .left_b (rd_left_b), .top_b (rd_top_b), .w_b (rd_w_b), .h_b (rd_h_b),
    .overlap(pair_ovl_s)
  );

  assign hit_s     = cmp_v_q && pair_ovl_s && (cmp_i_q != cmp_j_q);
  assign row_end_s = cmp_v_q && (cmp_j_q == LAST);

  // Issue stage advance, compare-stage redirects (early exit / isolated row) and result updates.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    iss_v_d   = iss_v_q;
    cmp_i_d   = addr_a_q;
    cmp_j_d   = addr_b_q;
    cmp_v_d   = 1'b0;
    row_hit_d = row_hit_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    found_d   = found_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mode_d    = mode;
          found_d   = 1'b0;
          idx_d     = IDX_ZERO;
          cnt_d     = {(IDX_W+1){1'b0}};
          row_hit_d = 1'b0;
          addr_a_d  = IDX_ZERO;
          addr_b_d  = IDX_ZERO;
          iss_v_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = SCAN;
        end else begin
          busy_d = 1'b0;
        end
      end
      SCAN, DRAIN: begin
        cmp_v_d = iss_v_q;
        if (iss_v_q && (addr_b_q != LAST)) begin
          addr_b_d = addr_b_q + IDX_ONE;
        end else if (iss_v_q && (addr_a_q != LAST)) begin
          addr_a_d = addr_a_q + IDX_ONE;
          addr_b_d = IDX_ZERO;
        end else if (iss_v_q) begin
          iss_v_d = 1'b0;
          state_d = DRAIN;
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        // Compare-stage decisions override the plain issue advance above.
        if (hit_s && !row_end_s) begin
          cmp_v_d   = 1'b0;
          row_hit_d = 1'b0;
          cnt_d     = (mode_q == MODE_COUNT) ? (cnt_q + CNT_ONE) : cnt_q;
          if (cmp_i_q == LAST) begin
            iss_v_d = 1'b0;
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_a_d = cmp_i_q + IDX_ONE;
            addr_b_d = IDX_ZERO;
            iss_v_d  = 1'b1;
            state_d  = SCAN;
          end
        end else if (row_end_s) begin
          row_hit_d = 1'b0;
          if (hit_s || row_hit_q) begin
            cnt_d = (mode_q == MODE_COUNT) ? (cnt_q + CNT_ONE) : cnt_q;
          end else if (mode_q == MODE_FIND) begin
            found_d = 1'b1;
            idx_d   = cmp_i_q;
            cmp_v_d = 1'b0;
            iss_v_d = 1'b0;
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          row_hit_d = row_hit_q | hit_s;
        end
      end
      default: begin
        state_d = IDLE;
        iss_v_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_FIND;
      addr_a_q  <= IDX_ZERO;
      addr_b_q  <= IDX_ZERO;
      iss_v_q   <= 1'b0;
      cmp_i_q   <= IDX_ZERO;
      cmp_j_q   <= IDX_ZERO;
      cmp_v_q   <= 1'b0;
      row_hit_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      idx_q     <= IDX_ZERO;
      cnt_q     <= {(IDX_W+1){1'b0}};
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      iss_v_q   <= iss_v_d;
      cmp_i_q   <= cmp_i_d;
      cmp_j_q   <= cmp_j_d;
      cmp_v_q   <= cmp_v_d;
      row_hit_q <= row_hit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign result_idx = idx_q;
  assign result_cnt = cnt_q;
  assign rd_addr_a  = addr_a_q;
  assign rd_addr_b  = addr_b_q;

endmodule

// File: tb/tb_claim_overlap_scanner.sv
// Bench for claim_overlap_scanner: table vectors, control/reset sequences, and randomized claim sets
// checked against a pairwise-overlap reference model.
module tb_claim_overlap_scanner;
  localparam int N  = 4;
  localparam int IW = 3;
  localparam int CW = 10;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, mode = 1'b0;
  logic busy, done, found;
  logic [IW-1:0] rd_addr_a, rd_addr_b, result_idx;
  logic [IW:0]   result_cnt;
  logic [CW-1:0] rd_left_a, rd_top_a, rd_left_b, rd_top_b;
  logic [SW-1:0] rd_w_a, rd_h_a, rd_w_b, rd_h_b;

  logic start1 = 1'b0, mode_1 = 1'b0;
  logic busy1, done1, found1;
  logic [0:0] rd_addr_a1, rd_addr_b1, result_idx1;
  logic [1:0] result_cnt1;
  logic [CW-1:0] rd_left_a1, rd_top_a1, rd_left_b1, rd_top_b1;
  logic [SW-1:0] rd_w_a1, rd_h_a1, rd_w_b1, rd_h_b1;

  logic [CW-1:0] mem_l[8], mem_t[8];
  logic [SW-1:0] mem_w[8], mem_h[8];
  logic [CW-1:0] mem1_c[2];
  logic [SW-1:0] mem1_s[2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Synchronous-read claim storage, one-cycle latency.
  always @(posedge clk) begin
    rd_left_a <= mem_l[rd_addr_a]; rd_top_a <= mem_t[rd_addr_a];
    rd_w_a    <= mem_w[rd_addr_a]; rd_h_a   <= mem_h[rd_addr_a];
    rd_left_b <= mem_l[rd_addr_b]; rd_top_b <= mem_t[rd_addr_b];
    rd_w_b    <= mem_w[rd_addr_b]; rd_h_b   <= mem_h[rd_addr_b];
    rd_left_a1 <= mem1_c[rd_addr_a1]; rd_top_a1 <= mem1_c[rd_addr_a1];
    rd_w_a1    <= mem1_s[rd_addr_a1]; rd_h_a1   <= mem1_s[rd_addr_a1];
    rd_left_b1 <= mem1_c[rd_addr_b1]; rd_top_b1 <= mem1_c[rd_addr_b1];
    rd_w_b1    <= mem1_s[rd_addr_b1]; rd_h_b1   <= mem1_s[rd_addr_b1];
  end

  claim_overlap_scanner #(.N_CLAIMS(N), .IDX_W(IW), .COORD_W(CW), .SIZE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_left_a(rd_left_a), .rd_top_a(rd_top_a), .rd_w_a(rd_w_a), .rd_h_a(rd_h_a),
    .rd_left_b(rd_left_b), .rd_top_b(rd_top_b), .rd_w_b(rd_w_b), .rd_h_b(rd_h_b),
    .found(found), .result_idx(result_idx), .result_cnt(result_cnt)
  );

  claim_overlap_scanner #(.N_CLAIMS(1), .IDX_W(1), .COORD_W(CW), .SIZE_W(SW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode_1), .busy(busy1), .done(done1),
    .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1),
    .rd_left_a(rd_left_a1), .rd_top_a(rd_top_a1), .rd_w_a(rd_w_a1), .rd_h_a(rd_h_a1),
    .rd_left_b(rd_left_b1), .rd_top_b(rd_top_b1), .rd_w_b(rd_w_b1), .rd_h_b(rd_h_b1),
    .found(found1), .result_idx(result_idx1), .result_cnt(result_cnt1)
  );

  typedef struct {
    string name;
    int l[N]; int t[N]; int w[N]; int h[N];
    bit md; int ef; int ei; int ec; int max_lat;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: claim a overlaps claim b in the strict-area sense, using unbounded integer edges.
  function automatic bit ref_ovl(input int a, input int b);
    int la, ra, ta, ba, lb, rb, tb, bb;
    la = int'(mem_l[a]); ra = la + int'(mem_w[a]); ta = int'(mem_t[a]); ba = ta + int'(mem_h[a]);
    lb = int'(mem_l[b]); rb = lb + int'(mem_w[b]); tb = int'(mem_t[b]); bb = tb + int'(mem_h[b]);
    return (a != b) && (la < rb) && (lb < ra) && (ta < bb) && (tb < ba);
  endfunction

  task automatic ref_model(input bit md, output int f, output int idx, output int cnt);
    int n_over;
    f = 0; idx = 0; cnt = 0;
    for (int a = 0; a < N; a++) begin
      n_over = 0;
      for (int b = 0; b < N; b++) n_over += int'(ref_ovl(a, b));
      if (md && n_over > 0) cnt++;
      if (!md && n_over == 0 && f == 0) begin f = 1; idx = a; end
    end
  endtask

  task automatic run_scan(input bit m, input string nm, output int lat);
    start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m;
    chk({nm, "_acc_busy"}, int'(busy), 1);
    chk({nm, "_acc_done"}, int'(done), 0);
    chk({nm, "_acc_found"}, int'(found), 0);
    chk({nm, "_acc_cnt"}, int'(result_cnt), 0);
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_done_seen"}, int'(done), 1);
    chk({nm, "_busy_low"}, int'(busy), 0);
  endtask

  task automatic load_vec(input int v);
    for (int c = 0; c < N; c++) begin
      mem_l[c] = CW'(vecs[v].l[c]); mem_t[c] = CW'(vecs[v].t[c]);
      mem_w[c] = SW'(vecs[v].w[c]); mem_h[c] = SW'(vecs[v].h[c]);
    end
  endtask

  initial begin
    int lat, ef, ei, ec, seen;
    for (int c = 0; c < 8; c++) begin
      mem_l[c] = '0; mem_t[c] = '0; mem_w[c] = '0; mem_h[c] = '0;
    end
    mem1_c[0] = 10'd5; mem1_c[1] = 10'd5; mem1_s[0] = 5'd3; mem1_s[1] = 5'd3;

    vecs[0] = '{"aoc_find",  '{1,3,5,900}, '{3,1,5,900}, '{4,4,2,2}, '{4,4,2,2}, 1'b0, 1, 2, 0, 19};
    vecs[1] = '{"aoc_count", '{1,3,5,900}, '{3,1,5,900}, '{4,4,2,2}, '{4,4,2,2}, 1'b1, 0, 0, 2, 19};
    vecs[2] = '{"disjoint_find", '{0,10,20,30}, '{0,0,0,0}, '{2,2,2,2}, '{2,2,2,2}, 1'b0, 1, 0, 0, 6};
    vecs[3] = '{"ident_find",  '{0,0,0,0}, '{0,0,0,0}, '{3,3,3,3}, '{3,3,3,3}, 1'b0, 0, 0, 0, 19};
    vecs[4] = '{"ident_count", '{0,0,0,0}, '{0,0,0,0}, '{3,3,3,3}, '{3,3,3,3}, 1'b1, 0, 0, 4, 15};
    vecs[5] = '{"edge_zero_count", '{0,2,0,500}, '{0,0,0,500}, '{2,2,0,3}, '{2,2,2,3}, 1'b1, 0, 0, 0, 19};
    vecs[6] = '{"edge_zero_find",  '{0,2,0,500}, '{0,0,0,500}, '{2,2,0,3}, '{2,2,2,3}, 1'b0, 1, 0, 0, 19};
    vecs[7] = '{"nowrap_count", '{1023,0,100,200}, '{0,0,100,200}, '{31,5,1,1}, '{4,4,1,1}, 1'b1, 0, 0, 0, 19};
    vecs[8] = '{"wide_count", '{1000,1010,0,0}, '{0,0,100,200}, '{31,5,1,1}, '{4,4,1,1}, 1'b1, 0, 0, 2, 19};
    vecs[9] = '{"wide_find",  '{1000,1010,0,0}, '{0,0,100,200}, '{31,5,1,1}, '{4,4,1,1}, 1'b0, 1, 2, 0, 19};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_idx", int'(result_idx), 0);
    chk("rst_cnt", int'(result_cnt), 0);
    chk("rst_addr_a", int'(rd_addr_a), 0);
    chk("rst_addr_b", int'(rd_addr_b), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      load_vec(v);
      run_scan(vecs[v].md, vecs[v].name, lat);
      chk({vecs[v].name, "_found"}, int'(found), vecs[v].ef);
      chk({vecs[v].name, "_idx"}, int'(result_idx), vecs[v].ei);
      chk({vecs[v].name, "_cnt"}, int'(result_cnt), vecs[v].ec);
      chk({vecs[v].name, "_lat_ok"}, int'(lat <= vecs[v].max_lat), 1);
      @(posedge clk); #1;
      chk({vecs[v].name, "_done_pulse"}, int'(done), 0);
      chk({vecs[v].name, "_hold_cnt"}, int'(result_cnt), vecs[v].ec);
    end

    // Back-to-back: new start in the done cycle clears results on acceptance.
    load_vec(1);
    run_scan(1'b1, "b2b_first", lat);
    chk("b2b_first_cnt", int'(result_cnt), 2);
    run_scan(1'b0, "b2b_second", lat);
    chk("b2b_second_found", int'(found), 1);
    chk("b2b_second_idx", int'(result_idx), 2);
    chk("b2b_second_cnt", int'(result_cnt), 0);

    // start pulsed while busy is ignored; mode stays as latched.
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_busy", int'(busy), 1);
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_start_done", int'(done), 1);
    chk("busy_start_cnt", int'(result_cnt), 2);
    chk("busy_start_found", int'(found), 0);
    @(posedge clk); #1;

    // Reset mid-scan aborts with no done pulse.
    load_vec(4);
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_reset_cnt_nonzero", int'(result_cnt != 0), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_cnt", int'(result_cnt), 0);
    chk("midrst_found", int'(found), 0);
    chk("midrst_addr_b", int'(rd_addr_b), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("midrst_no_done", seen, 0);

    // Single-claim instance: (0,0) is excluded, so the claim is isolated.
    start1 = 1'b1; mode_1 = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("n1_find_done", int'(done1), 1);
    chk("n1_find_found", int'(found1), 1);
    chk("n1_find_idx", int'(result_idx1), 0);
    @(posedge clk); #1;
    start1 = 1'b1; mode_1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("n1_count_done", int'(done1), 1);
    chk("n1_count_cnt", int'(result_cnt1), 0);
    chk("n1_count_found", int'(found1), 0);

    // Randomized small claim sets, dense enough to give a mix of overlaps.
    for (int r = 0; r < 40; r++) begin
      bit md;
      for (int c = 0; c < N; c++) begin
        mem_l[c] = CW'($urandom_range(12, 0));
        mem_t[c] = CW'($urandom_range(12, 0));
        mem_w[c] = SW'($urandom_range(5, 0));
        mem_h[c] = SW'($urandom_range(5, 0));
      end
      md = 1'($urandom_range(1, 0));
      ref_model(md, ef, ei, ec);
      run_scan(md, $sformatf("rnd%0d", r), lat);
      chk($sformatf("rnd%0d_found", r), int'(found), ef);
      chk($sformatf("rnd%0d_idx", r), int'(result_idx), ei);
      chk($sformatf("rnd%0d_cnt", r), int'(result_cnt), ec);
      chk($sformatf("rnd%0d_lat_ok", r), int'(lat <= N * N + 3), 1);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/claim_overlap_scanner.md
# claim_overlap_scanner

Parametrised all-pairs rectangle-overlap scanner for claim lists held in synchronous-read storage. It reads claim pairs through two 1-cycle-latency read ports and tests each pair for strict area overlap. Mode 0 reports the first claim that overlaps no other claim; mode 1 counts the claims that overlap at least one other. It sits between the claim ROM and the result exporter, under a start/done handshake.

## Interface
- N_CLAIMS, 1237, number of claims, indices 0..N_CLAIMS-1, minimum 1
- IDX_W, 11, index/count width, 2^IDX_W > N_CLAIMS
- COORD_W, 10, left/top width
- SIZE_W, 5, w/h width

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin scan; sampled in IDLE/DONE only
- mode  in  1  0 = find first isolated claim, 1 = count overlapping claims; latched on start
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at scan end
- rd_addr_a, rd_addr_b  out  IDX_W  storage read addresses (outer i, inner j)
- rd_left_a/b, rd_top_a/b  in  COORD_W  claim origin, valid 1 cycle after address
- rd_w_a/b, rd_h_a/b  in  SIZE_W  claim size, same latency
- found  out  1  mode 0: an isolated claim exists
- result_idx  out  IDX_W  mode 0: lowest isolated index, else 0
- result_cnt  out  IDX_W+1  mode 1: number of claims with ≥1 overlap

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- Reset: state IDLE; busy, done, found = 0; result_idx, result_cnt = 0; rd_addr_a/b = 0; pipeline valid = 0. Reset mid-scan aborts with no done pulse.
- IDLE/DONE + start=1: latch mode, clear found/result_idx/result_cnt/row flag, set i = j = 0, go to SCAN, busy=1. start while busy is ignored.
- SCAN issue stage: drive (i,j). Advance j; on j = N_CLAIMS-1 the next pair is (i+1,0). After issuing (N_CLAIMS-1, N_CLAIMS-1), go to DRAIN.
- Compare stage: a one-cycle-delayed copy of (i,j,valid) pairs with the returned data.
- right = left + w and bottom = top + h are computed at COORD_W+1 bits, with no wrap.
- Overlap holds iff NOT (l_a ≥ r_b OR r_a ≤ l_b OR t_a ≥ b_b OR b_a ≤ t_b) AND i ≠ j.
- Edge-touching claims and zero-area claims never overlap.
- Overlap at compare (i,j) with j < N_CLAIMS-1 (early exit):
  - The in-flight pair is squashed (valid cleared).
  - Next issue is (i+1,0), or DRAIN→DONE if i = N_CLAIMS-1.
  - Mode 1: result_cnt += 1.
- Compare (i, N_CLAIMS-1) with the row flag clear and no overlap means row i is isolated.
  - Mode 0: found=1, result_idx=i, squash the in-flight pair, go to DONE.
  - Mode 1: no count.
- Overlap detected at j = N_CLAIMS-1 counts as overlapping.
- DRAIN: one cycle, evaluates the last compare, then DONE.
- DONE: done=1 for exactly one cycle on entry, busy=0. Results hold until the next accepted start.

## Timing
- Throughput: one pair per cycle, with no bubble between rows that have no overlap.
- Row with first overlap at j costs j+2 issue cycles.
- Worst case: start → done ≤ N_CLAIMS² + 3 cycles.
- Mode 0 early termination: done is asserted 2 cycles after (i, N_CLAIMS-1) is issued.
- Outputs are registered; there are no combinational paths from the rd_* inputs to outputs.
- N_CLAIMS = 1: the only pair is (0,0), which is excluded, so mode 0 gives found=1, idx 0 and mode 1 gives cnt 0.

## Structure
- Package claim_scan_pkg: state enum (IDLE, SCAN, DRAIN, DONE) and MODE_FIND / MODE_COUNT constants.
- Sub-module rect_overlap_cmp: parametrised by COORD_W/SIZE_W, combinational strict-overlap test with widened edges; instantiated once in the compare stage.

## Test plan
- AoC example, 0-based claims: 0 @1,3 4x4; 1 @3,1 4x4; 2 @5,5 2x2. Mode 0 → found=1, result_idx=2. Mode 1 → result_cnt=2.
- 4 disjoint claims, mode 0 → found=1, result_idx=0, done within 6 cycles of start.
- 4 identical claims 0,0 3x3:
  - Mode 0 → found=0, result_idx=0, done within N²+3 cycles.
  - Mode 1 → result_cnt=4, with each row exiting at j ≤ 1.
- Edge touching (0,0 2x2 and 2,0 2x2), plus one zero-width claim on top of the first, mode 1 → result_cnt=0.
- Claim at left=1023, w=31, plus one at left=0, w=5 (no 10-bit wrap) → no overlap, cnt 0.
- Control and reset:
  - rst_n low mid-scan → busy=0, results 0, no done pulse.
  - start pulsed during busy → ignored, results unchanged.
  - Back-to-back start in DONE → new scan, with results cleared on acceptance.
